// File: rtl/instruction_program_writer_pkg.sv
// Shared instruction-set definitions for the program writer and the fetch/decode path.
package instruction_program_writer_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned ONEHOT_W = 8;

   // Opcode encodings
   localparam logic [OPCODE_W-1:0] OP_LOAD      = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_ADD       = 4'b0100;
   localparam logic [OPCODE_W-1:0] OP_BITAND    = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_SUB       = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_INPUT     = 4'b1010;
   localparam logic [OPCODE_W-1:0] OP_OUTPUT    = 4'b1110;
   localparam logic [OPCODE_W-1:0] OP_JUMP      = 4'b1000;
   localparam logic [OPCODE_W-1:0] OP_JUMP_COND = 4'b1001;

   // One-hot request bit positions
   localparam int unsigned IDX_LOAD      = 7;
   localparam int unsigned IDX_ADD       = 6;
   localparam int unsigned IDX_BITAND    = 5;
   localparam int unsigned IDX_SUB       = 4;
   localparam int unsigned IDX_INPUT     = 3;
   localparam int unsigned IDX_OUTPUT    = 2;
   localparam int unsigned IDX_JUMP      = 1;
   localparam int unsigned IDX_JUMP_COND = 0;

   // Writer FSM states
   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_WRITE  = 2'd1,
      ST_FULL   = 2'd2
   } state_e;

endpackage

// File: rtl/onehot_to_opcode.sv
// Combinational one-hot request to 4-bit opcode encoder with exactly-one-hot check.
module onehot_to_opcode
   import instruction_program_writer_pkg::*;
(
   input  logic [ONEHOT_W-1:0] onehot_i,
   output logic [OPCODE_W-1:0] opcode_o,
   output logic                valid_o
);

   logic [3:0] ones;

   // Population count for the validity check, then priority-select the opcode
   always_comb begin
      ones     = 4'd0;
      opcode_o = OP_LOAD;
      for (int i = 0; i < int'(ONEHOT_W); i++) begin
         ones = ones + 4'(onehot_i[i]);
      end
      valid_o = (ones == 4'd1);
      if      (onehot_i[IDX_LOAD])      opcode_o = OP_LOAD;
      else if (onehot_i[IDX_ADD])       opcode_o = OP_ADD;
      else if (onehot_i[IDX_BITAND])    opcode_o = OP_BITAND;
      else if (onehot_i[IDX_SUB])       opcode_o = OP_SUB;
      else if (onehot_i[IDX_INPUT])     opcode_o = OP_INPUT;
      else if (onehot_i[IDX_OUTPUT])    opcode_o = OP_OUTPUT;
      else if (onehot_i[IDX_JUMP])      opcode_o = OP_JUMP;
      else if (onehot_i[IDX_JUMP_COND]) opcode_o = OP_JUMP_COND;
   end

endmodule

// File: rtl/instruction_program_writer.sv
// Encodes one-hot instruction requests and writes {opcode, operand} words sequentially
// into program memory, flagging malformed requests and reporting a full program.
module instruction_program_writer
   import instruction_program_writer_pkg::*;
#(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned OPERAND_W = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ONEHOT_W-1:0]           op_onehot,
   input  logic [OPERAND_W-1:0]          operand_in,
   input  logic                          valid_in,
   output logic                          ready_out,
   input  logic                          clear_in,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [OPCODE_W+OPERAND_W-1:0] mem_wdata,
   output logic                          err_invalid,
   output logic                          prog_full,
   output logic [ADDR_W:0]               prog_count
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   state_e                          state_q;
   logic                            mem_we_q;
   logic [ADDR_W-1:0]               addr_q;
   logic [OPCODE_W+OPERAND_W-1:0]   wdata_q;
   logic                            err_q;
   logic                            full_q;
   logic [ADDR_W:0]                 count_q;

   logic [OPCODE_W-1:0]             enc_opcode;
   logic                            enc_valid;
   logic                            handshake;

   onehot_to_opcode u_enc (
      .onehot_i (op_onehot),
      .opcode_o (enc_opcode),
      .valid_o  (enc_valid)
   );

   // A clear in the same cycle blocks acceptance of any request
   always_comb begin
      ready_out = (state_q == ST_ACCEPT) && !clear_in;
      handshake = valid_in && ready_out;
   end

   // Writer FSM with address/count tracking; all memory-side outputs are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_ACCEPT;
         mem_we_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         full_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_we_q <= 1'b0;
         err_q    <= 1'b0;
         if (clear_in) begin
            state_q <= ST_ACCEPT;
            addr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_ACCEPT: begin
                  if (handshake) begin
                     if (enc_valid) begin
                        state_q  <= ST_WRITE;
                        mem_we_q <= 1'b1;
                        wdata_q  <= {enc_opcode, operand_in};
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               ST_WRITE: begin
                  count_q <= count_q + (ADDR_W+1)'(1);
                  if (addr_q == ADDR_LAST) begin
                     state_q <= ST_FULL;
                     full_q  <= 1'b1;
                  end else begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     state_q <= ST_ACCEPT;
                  end
               end
               ST_FULL: begin
                  state_q <= ST_FULL;
               end
               default: begin
                  state_q <= ST_ACCEPT;
               end
            endcase
         end
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign err_invalid = err_q;
   assign prog_full   = full_q;
   assign prog_count  = count_q;

endmodule

// File: tb/tb_instruction_program_writer.sv
// Self-checking bench for instruction_program_writer: directed steps plus randomized traffic
// compared against a program-list reference model.
module tb_instruction_program_writer;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned OPERAND_W = 4;
   localparam int          DEPTH     = 16;

   // Opcode by one-hot bit position (index 0 = jump_cond ... index 7 = load)
   localparam logic [3:0] OPC_TAB [8] = '{4'h9, 4'h8, 4'hE, 4'hA, 4'h6, 4'h1, 4'h4, 4'h0};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  op_onehot = 8'h00;
   logic [3:0]  operand_in = 4'h0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic        clear_in = 1'b0;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        err_invalid;
   logic        prog_full;
   logic [4:0]  prog_count;

   int checks   = 0;
   int failures = 0;

   // Reference model: list of committed words plus an in-flight write
   logic [7:0] prog_q [$];
   logic       pend = 1'b0;
   logic [7:0] pword = 8'h00;
   logic       e_we = 1'b0;
   logic [7:0] e_wdata = 8'h00;
   logic       e_err = 1'b0;

   instruction_program_writer #(.ADDR_W(ADDR_W), .OPERAND_W(OPERAND_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .op_onehot   (op_onehot),
      .operand_in  (operand_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .clear_in    (clear_in),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .err_invalid (err_invalid),
      .prog_full   (prog_full),
      .prog_count  (prog_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] opc_of(input logic [7:0] op);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 0; i < 8; i++) if (op[i]) r = OPC_TAB[i];
      return r;
   endfunction

   function automatic logic [7:0] onehot_of_opc(input logic [3:0] opc);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) if (OPC_TAB[i] == opc) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [7:0] rand_op();
      if ($urandom_range(0, 3) != 0) return 8'(1 << $urandom_range(0, 7));
      return 8'($urandom);
   endfunction

   // One clock: drive inputs, check ready, advance model, clock, check registered outputs
   task automatic cycle(input logic r, input logic c, input logic v,
                        input logic [7:0] op, input logic [3:0] opd);
      logic exp_ready;
      int   sz;
      rst = r; clear_in = c; valid_in = v; op_onehot = op; operand_in = opd;
      #1;
      exp_ready = !pend && (prog_q.size() < DEPTH) && !c;
      if (!r) chk("ready_out", 16'(ready_out), 16'(exp_ready));
      e_we  = 1'b0;
      e_err = 1'b0;
      if (r) begin
         prog_q.delete();
         pend    = 1'b0;
         e_wdata = 8'h00;
      end else if (c) begin
         prog_q.delete();
         pend = 1'b0;
      end else if (pend) begin
         prog_q.push_back(pword);
         pend = 1'b0;
      end else if (v && prog_q.size() < DEPTH) begin
         if ($countones(op) == 1) begin
            pend    = 1'b1;
            pword   = {opc_of(op), opd};
            e_we    = 1'b1;
            e_wdata = pword;
         end else begin
            e_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      sz = prog_q.size();
      chk("mem_we", 16'(mem_we), 16'(e_we));
      chk("mem_addr", 16'(mem_addr), 16'((pend || sz < DEPTH) ? sz : DEPTH - 1));
      chk("mem_wdata", 16'(mem_wdata), 16'(e_wdata));
      chk("err_invalid", 16'(err_invalid), 16'(e_err));
      chk("prog_full", 16'(prog_full), 16'(sz == DEPTH));
      chk("prog_count", 16'(prog_count), 16'(sz));
   endtask

   initial begin
      logic [7:0] op;
      @(posedge clk);
      #1;
      // Reset held two cycles, then an idle cycle
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

      // Every legal op, then decode the written opcode back to one-hot
      for (int i = 7; i >= 0; i--) begin
         op = 8'(1 << i);
         cycle(1'b0, 1'b0, 1'b1, op, 4'h5);
         chk("decode_roundtrip", 16'(onehot_of_opc(mem_wdata[7:4])), 16'(op));
         cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
      end

      // Malformed requests
      cycle(1'b0, 1'b0, 1'b1, 8'h00, 4'h3);
      cycle(1'b0, 1'b0, 1'b1, 8'h81, 4'h3);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

      // Clear, then fill to full with mixed random requests
      cycle(1'b0, 1'b1, 1'b1, 8'h40, 4'h1);
      for (int k = 0; k < 400 && prog_q.size() < DEPTH; k++)
         cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), rand_op(), 4'($urandom));
      chk("fill_reached", 16'(prog_q.size()), 16'(DEPTH));
      // Requests while full are ignored
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'h10, 4'hA);
      cycle(1'b0, 1'b0, 1'b1, 8'h03, 4'hA);

      // Clear in FULL, next write goes to address 0
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
      cycle(1'b0, 1'b0, 1'b1, 8'h02, 4'h7);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

      // Clear during the write cycle, then reset during the write cycle
      cycle(1'b0, 1'b0, 1'b1, 8'h20, 4'hC);
      cycle(1'b0, 1'b1, 1'b1, 8'h20, 4'hC);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
      cycle(1'b0, 1'b0, 1'b1, 8'h01, 4'hD);
      cycle(1'b1, 1'b0, 1'b1, 8'h01, 4'hD);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 9) < 7), rand_op(), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
